// File: rtl/nodf_module_monitor.sv
// Transaction monitor for an ap_ctrl-style module: counts starts/dones, tracks per-transaction latency
// through a timestamp FIFO, flags protocol errors; outputs are registered (1-cycle latency), never backpressures.
module nodf_module_monitor #(
  parameter int CNT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic [CNT_W-1:0] last_interval,
  output logic [2:0]       err,
  output logic             dump_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;

  logic [CNT_W-1:0] ts_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] prev_start;
  logic             have_prev;
  logic             finished;
  logic             start_wait;

  logic             start_ev;
  logic             done_ev;
  logic             active;
  logic             fifo_empty;
  logic             fifo_full;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             lat_vld;
  logic [CNT_W-1:0] lat;

  always_comb begin
    start_ev   = ap_start & ap_ready;
    done_ev    = ap_done & ap_continue;
    active     = ~finished & ~finish;
    fifo_empty = (occ == '0);
    fifo_full  = (occ == OW'(DEPTH));
    // A start and done on an empty FIFO pair up directly with zero latency.
    bypass     = start_ev & done_ev & fifo_empty;
    // When full, a simultaneous pop frees the slot the push lands in.
    push       = active & start_ev & ~bypass & (~fifo_full | done_ev);
    pop        = active & done_ev & ~fifo_empty;
    lat_vld    = active & (bypass | pop);
    lat        = bypass ? '0 : (cycle_cnt - ts_mem[rd_ptr]);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      ts_mem[wr_ptr] <= cycle_cnt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      cycle_cnt     <= '0;
      prev_start    <= '0;
      have_prev     <= 1'b0;
      finished      <= 1'b0;
      start_wait    <= 1'b0;
      status        <= 2'b00;
      start_cnt     <= '0;
      done_cnt      <= '0;
      last_latency  <= '0;
      max_latency   <= '0;
      last_interval <= '0;
      err           <= 3'b000;
      dump_valid    <= 1'b0;
    end else begin
      dump_valid <= finish & ~finished;
      start_wait <= ap_start & ~ap_ready;
      if (finish) begin
        finished <= 1'b1;
      end

      if (finished | finish) begin
        status <= 2'b11;
      end else if (ap_done & ~ap_continue) begin
        status <= 2'b10;
      end else if (~fifo_empty | ap_start) begin
        status <= 2'b01;
      end else begin
        status <= 2'b00;
      end

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase

      // Everything statistical freezes from the first finish edge onward.
      if (active) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);

        if (start_ev) begin
          start_cnt  <= start_cnt + CNT_W'(1);
          prev_start <= cycle_cnt;
          have_prev  <= 1'b1;
          if (have_prev) begin
            last_interval <= cycle_cnt - prev_start;
          end
          if (fifo_full & ~done_ev) begin
            err[1] <= 1'b1;
          end
        end

        if (done_ev) begin
          done_cnt <= done_cnt + CNT_W'(1);
          if (fifo_empty & ~start_ev) begin
            err[0] <= 1'b1;
          end
        end

        if (lat_vld) begin
          last_latency <= lat;
          if (lat > max_latency) begin
            max_latency <= lat;
          end
        end

        if (start_wait & ~ap_start) begin
          err[2] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nodf_module_monitor.sv
// Directed bench for nodf_module_monitor: a queue-based reference model with a latency scoreboard.
module tb_nodf_module_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_continue = 1'b1;
  logic        finish = 1'b0;
  logic [1:0]  status;
  logic [31:0] start_cnt;
  logic [31:0] done_cnt;
  logic [31:0] last_latency;
  logic [31:0] max_latency;
  logic [31:0] last_interval;
  logic [2:0]  err;
  logic        dump_valid;

  nodf_module_monitor #(.CNT_W(32), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .status(status), .start_cnt(start_cnt), .done_cnt(done_cnt),
    .last_latency(last_latency), .max_latency(max_latency),
    .last_interval(last_interval), .err(err), .dump_valid(dump_valid)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] ts_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_cyc, m_start, m_done, m_last, m_max, m_int, m_prev;
  logic        m_have, m_fin, m_wait, m_dump;
  logic [2:0]  m_err;
  logic [1:0]  m_status;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    ts_q.delete();
    exp_q.delete();
    m_cyc = '0; m_start = '0; m_done = '0; m_last = '0; m_max = '0;
    m_int = '0; m_prev = '0; m_have = 1'b0; m_fin = 1'b0; m_wait = 1'b0;
    m_dump = 1'b0; m_err = 3'b000; m_status = 2'b00;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".status"},   32'(status),     32'(m_status));
    chk({tag, ".start"},    start_cnt,       m_start);
    chk({tag, ".done"},     done_cnt,        m_done);
    chk({tag, ".last_lat"}, last_latency,    m_last);
    chk({tag, ".max_lat"},  max_latency,     m_max);
    chk({tag, ".interval"}, last_interval,   m_int);
    chk({tag, ".err"},      32'(err),        32'(m_err));
    chk({tag, ".dump"},     32'(dump_valid), 32'(m_dump));
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, then compare.
  task automatic step(input logic s, input logic r, input logic d, input logic c,
                      input logic f, input string tag);
    logic        st, dn, byp;
    logic [31:0] lat;
    int          occ_pre;
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
    @(posedge clock);
    #1;
    st = s & r;
    dn = d & c;
    byp = 1'b0;
    occ_pre = ts_q.size();
    if (!m_fin && !f) begin
      if (dn) begin
        m_done = m_done + 1;
        if (ts_q.size() != 0) exp_q.push_back(m_cyc - ts_q.pop_front());
        else if (st) begin exp_q.push_back(32'd0); byp = 1'b1; end
        else m_err[0] = 1'b1;
      end
      if (st) begin
        m_start = m_start + 1;
        if (m_have) m_int = m_cyc - m_prev;
        m_prev = m_cyc;
        m_have = 1'b1;
        if (!byp) begin
          if (ts_q.size() < 4) ts_q.push_back(m_cyc);
          else m_err[1] = 1'b1;
        end
      end
      if (m_wait && !s) m_err[2] = 1'b1;
      m_cyc = m_cyc + 1;
    end
    m_dump = f && !m_fin;
    if (f) m_fin = 1'b1;
    m_wait = s && !r;
    m_status = m_fin ? 2'b11 : (d && !c) ? 2'b10 : (occ_pre != 0 || s) ? 2'b01 : 2'b00;
    while (exp_q.size() != 0) begin
      lat = exp_q.pop_front();
      chk({tag, ".sb_lat"}, last_latency, lat);
      m_last = lat;
      if (lat > m_max) m_max = lat;
    end
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b1; finish = 1'b0;
    @(posedge clock);
    #1;
    model_clear();
    check_all(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    do_reset("rst0");

    // Single transaction, latency 5
    step(0, 0, 0, 1, 0, "t1_idle");
    step(1, 1, 0, 1, 0, "t1_start");
    chk("t1_busy", 32'(status), 32'd1);
    repeat (4) step(0, 0, 0, 1, 0, "t1_wait");
    step(0, 0, 1, 1, 0, "t1_done");
    chk("t1_lat", last_latency, 32'd5);
    chk("t1_max", max_latency, 32'd5);
    chk("t1_dcnt", done_cnt, 32'd1);
    step(0, 0, 0, 1, 0, "t1_after");
    chk("t1_idle_st", 32'(status), 32'd0);

    // Pipelined back-to-back
    do_reset("rst1");
    repeat (3) step(1, 1, 0, 1, 0, "p_start");
    step(0, 0, 0, 1, 0, "p_gap");
    repeat (3) step(0, 0, 1, 1, 0, "p_done");
    chk("p_lat", last_latency, 32'd4);
    chk("p_int", last_interval, 32'd1);
    chk("p_dcnt", done_cnt, 32'd3);
    chk("p_err", 32'(err), 32'd0);

    // Simultaneous start/done: empty FIFO then non-empty FIFO
    step(1, 1, 1, 1, 0, "sim_empty");
    chk("sim_empty_lat", last_latency, 32'd0);
    step(1, 1, 0, 1, 0, "sim_s");
    step(1, 1, 1, 1, 0, "sim_sd");
    chk("sim_sd_lat", last_latency, 32'd1);
    step(0, 0, 1, 1, 0, "sim_d");
    step(0, 0, 0, 1, 0, "sim_idle");
    chk("sim_empty_st", 32'(status), 32'd0);

    // Overflow, then full FIFO with simultaneous start/done
    do_reset("rst2");
    repeat (5) step(1, 1, 0, 1, 0, "ovf_start");
    chk("ovf_err", 32'(err), 32'b010);
    chk("ovf_scnt", start_cnt, 32'd5);
    step(1, 1, 1, 1, 0, "ovf_sd");
    repeat (4) step(0, 0, 1, 1, 0, "ovf_drain");
    chk("ovf_drain_err", 32'(err), 32'b010);

    // Orphan done
    do_reset("rst3");
    step(0, 0, 1, 1, 0, "orphan");
    chk("orphan_err", 32'(err), 32'b001);
    chk("orphan_dcnt", done_cnt, 32'd1);
    chk("orphan_lat", last_latency, 32'd0);

    // Backpressure and dropped start
    do_reset("rst4");
    step(1, 1, 0, 1, 0, "bp_start");
    step(0, 0, 1, 0, 0, "bp_stall");
    chk("bp_status", 32'(status), 32'd2);
    chk("bp_dcnt", done_cnt, 32'd0);
    step(0, 0, 1, 1, 0, "bp_done");
    step(1, 0, 0, 1, 0, "drop_req");
    step(0, 0, 0, 1, 0, "drop_gone");
    chk("drop_err", 32'(err), 32'b100);

    // Asynchronous reset mid-transaction
    step(1, 1, 0, 1, 0, "mid_start");
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_scnt", start_cnt, 32'd0);
    chk("mid_rst_dcnt", done_cnt, 32'd0);
    chk("mid_rst_status", 32'(status), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    model_clear();
    ap_start = 1'b0; ap_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    step(0, 0, 0, 1, 0, "mid_after");
    step(1, 1, 0, 1, 0, "mid_s");
    step(0, 0, 1, 1, 0, "mid_d");
    chk("mid_lat", last_latency, 32'd1);

    // Finish freezes everything
    step(1, 1, 0, 1, 0, "fin_pre");
    step(0, 0, 0, 1, 1, "fin_cap");
    chk("fin_dump", 32'(dump_valid), 32'd1);
    chk("fin_status", 32'(status), 32'd3);
    step(1, 1, 0, 1, 0, "fin_s1");
    chk("fin_dump_low", 32'(dump_valid), 32'd0);
    step(1, 1, 1, 1, 1, "fin_s2");
    chk("fin_frozen_scnt", start_cnt, 32'd2);
    chk("fin_frozen_dcnt", done_cnt, 32'd1);
    chk("fin_status2", 32'(status), 32'd3);
    do_reset("rst_fin");
    chk("rst_fin_status", 32'(status), 32'd0);
    step(0, 0, 0, 1, 0, "post_fin");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
